// File: rtl/aes_decryptor.sv
// rtl/aes_decryptor.sv - iterative AES-128 inverse cipher, one operation per cycle
module aes_decryptor (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         valid,
    output logic [127:0] plaintext_out
);

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, DONE} state_t;

    state_t       cur_state, nxt_state;
    logic [127:0] st_q;
    logic [127:0] rk_q;
    logic [3:0]   round_q;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  p0, p1, p2, p3;
    logic [127:0] rk_fwd, rk_prev;

    assign {k0, k1, k2, k3} = rk_q;

    // forward expansion step: rk(r-1) -> rk(r) using Rcon[round]
    assign f0 = k0 ^ sub_rot_word(k3) ^ {rcon(round_q), 24'h0};
    assign f1 = k1 ^ f0;
    assign f2 = k2 ^ f1;
    assign f3 = k3 ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};

    // inverse expansion step: rk(r+1) -> rk(r) using Rcon[round+1]
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;
    assign p0 = k0 ^ sub_rot_word(p3) ^ {rcon(round_q + 4'd1), 24'h0};
    assign rk_prev = {p0, p1, p2, p3};

    logic [127:0] sub_xor;
    logic [127:0] mixed;

    // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns on top
    always_comb begin
        sub_xor = '0;
        mixed   = '0;
        for (int n = 0; n < 16; n++) begin
            sub_xor[127-8*n -: 8] = inv_sbox(st_q[127-8*(4*(((n/4) - (n%4)) & 3) + (n%4)) -: 8])
                                    ^ rk_prev[127-8*n -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 8] = gf_mul(sub_xor[127-32*c -: 8], 8'h0e) ^ gf_mul(sub_xor[119-32*c -: 8], 8'h0b)
                                 ^ gf_mul(sub_xor[111-32*c -: 8], 8'h0d) ^ gf_mul(sub_xor[103-32*c -: 8], 8'h09);
            mixed[119-32*c -: 8] = gf_mul(sub_xor[127-32*c -: 8], 8'h09) ^ gf_mul(sub_xor[119-32*c -: 8], 8'h0e)
                                 ^ gf_mul(sub_xor[111-32*c -: 8], 8'h0b) ^ gf_mul(sub_xor[103-32*c -: 8], 8'h0d);
            mixed[111-32*c -: 8] = gf_mul(sub_xor[127-32*c -: 8], 8'h0d) ^ gf_mul(sub_xor[119-32*c -: 8], 8'h09)
                                 ^ gf_mul(sub_xor[111-32*c -: 8], 8'h0e) ^ gf_mul(sub_xor[103-32*c -: 8], 8'h0b);
            mixed[103-32*c -: 8] = gf_mul(sub_xor[127-32*c -: 8], 8'h0b) ^ gf_mul(sub_xor[119-32*c -: 8], 8'h0d)
                                 ^ gf_mul(sub_xor[111-32*c -: 8], 8'h09) ^ gf_mul(sub_xor[103-32*c -: 8], 8'h0e);
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= IDLE;
        else        cur_state <= nxt_state;
    end

    // next-state logic
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE, DONE: if (start) nxt_state = KEXP;
            KEXP:       if (round_q == 4'd10) nxt_state = INIT;
            INIT:       nxt_state = ROUND;
            ROUND:      if (round_q == 4'd0) nxt_state = DONE;
            default:    nxt_state = IDLE;
        endcase
    end

    // datapath: state, round key, round counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q          <= '0;
            rk_q          <= '0;
            round_q       <= 4'd0;
            valid         <= 1'b0;
            plaintext_out <= '0;
        end else begin
            case (cur_state)
                IDLE, DONE: begin
                    if (start) begin
                        st_q    <= ciphertext;
                        rk_q    <= key;
                        round_q <= 4'd1;
                        valid   <= 1'b0;
                    end
                end
                KEXP: begin
                    rk_q    <= rk_fwd;
                    round_q <= round_q + 4'd1;
                end
                INIT: begin
                    st_q    <= st_q ^ rk_q;
                    round_q <= 4'd9;
                end
                ROUND: begin
                    st_q    <= (round_q != 4'd0) ? mixed : sub_xor;
                    rk_q    <= rk_prev;
                    round_q <= round_q - 4'd1;
                    if (round_q == 4'd0) begin
                        plaintext_out <= sub_xor;
                        valid         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decryptor.sv
// tb/tb_aes_decryptor.sv - randomized self-checking bench for aes_decryptor
module tb_aes_decryptor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         valid;
    logic [127:0] plaintext_out;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [7:0]   sb [256];
    logic [7:0]   isb[256];
    logic [31:0]  ks [44];
    logic [127:0] last_pt = '0;

    aes_decryptor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .key           (key),
        .ciphertext    (ciphertext),
        .valid         (valid),
        .plaintext_out (plaintext_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = xt(x);
        end
        return r;
    endfunction

    // S-box from the generator/inverse walk over GF(2^8)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 1;
        q = 1;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic void expand(input logic [127:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) ks[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = ks[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            ks[i] = ks[i-4] ^ t;
        end
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   m[4];
        logic [127:0] o;
        m = '{8'h02, 8'h03, 8'h01, 8'h01};
        expand(k);
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ ks[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[4*(((n/4) + (n%4)) % 4) + (n%4)]];
            if (r < 10) begin
                for (int n = 0; n < 16; n++) begin
                    s[n] = 0;
                    for (int j = 0; j < 4; j++) s[n] ^= mul(t[4*(n/4)+j], m[(j - (n%4) + 4) % 4]);
                end
            end else s = t;
            for (int n = 0; n < 16; n++) s[n] ^= ks[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] ct);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   m[4];
        logic [127:0] o;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        expand(k);
        for (int n = 0; n < 16; n++) s[n] = ct[127-8*n -: 8] ^ ks[40 + n/4][31-8*(n%4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int n = 0; n < 16; n++)
                t[n] = isb[s[4*(((n/4) + 4 - (n%4)) % 4) + (n%4)]] ^ ks[4*r + n/4][31-8*(n%4) -: 8];
            if (r > 0) begin
                for (int n = 0; n < 16; n++) begin
                    s[n] = 0;
                    for (int j = 0; j < 4; j++) s[n] ^= mul(t[4*(n/4)+j], m[(j - (n%4) + 4) % 4]);
                end
            end else s = t;
        end
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
        return o;
    endfunction

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // one request: accept, scramble inputs, bounded wait for valid, check latency/hold/result
    task automatic run(input string tag, input logic [127:0] k, input logic [127:0] c,
                       input logic [127:0] exp, input int inject);
        int   n;
        logic held;
        @(negedge clk);
        rst_n = 1'b1;
        key = k;
        ciphertext = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_at_accept"}, valid, 0);
        @(negedge clk);
        start = 1'b0;
        key = r128();
        ciphertext = r128();
        held = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) break;
            if (plaintext_out !== last_pt) held = 1'b0;
            if (n == inject) begin
                start = 1'b1;
                key = r128();
                ciphertext = r128();
            end else start = 1'b0;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, 21);
        check({tag, "_old_pt_held"}, held, 1);
        check({tag, "_plaintext"}, plaintext_out, exp);
        last_pt = exp;
    endtask

    initial begin
        logic [127:0] k, p, c;
        logic         seen;
        rst_n = 1'b0;
        start = 1'b0;
        key = '0;
        ciphertext = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", valid, 0);
        check("reset_pt", plaintext_out, 0);

        run("fips_c1", 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            128'h00112233445566778899aabbccddeeff, 0);
        run("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
            128'h3243f6a8885a308d313198a2e0370734, 0);
        k = 128'h000102030405060708090a0b0c0d0e0f;
        p = 128'h48656c6c6f2c2041455320576f726c64;
        run("hello_roundtrip", k, aes_enc(k, p), p, 0);
        run("busy_start", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
            128'h3243f6a8885a308d313198a2e0370734, 5);

        for (int i = 0; i < 6; i++) begin
            k = r128();
            p = r128();
            run("rand_roundtrip", k, aes_enc(k, p), p, 0);
            c = r128();
            run("rand_dec", k, c, aes_dec(k, c), 0);
        end

        // reset in the middle of a run
        @(negedge clk);
        key = r128();
        ciphertext = r128();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_valid", valid, 0);
        check("midrun_reset_pt", plaintext_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1'b1;
        end
        check("no_valid_after_abort", seen, 0);
        @(negedge clk);
        rst_n = 1'b0;
        last_pt = '0;
        repeat (2) @(posedge clk);
        run("first_edge_after_reset", 128'h000102030405060708090a0b0c0d0e0f,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/aes_decryptor.md
AES_DECRYPTOR -- requirements
Module: aes_decryptor

Interface
- REQ-001 SHALL have a single clock and an asynchronous active-low reset.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 rst_n  input  1  asynchronous active-low reset.
- REQ-004 start  input  1  request to decrypt; sampled at a rising edge only while in IDLE or DONE.
- REQ-005 key  input  128  AES-128 cipher key, sampled only at the edge that accepts start.
- REQ-006 ciphertext  input  128  block to decrypt, sampled only at the edge that accepts start.
- REQ-007 valid  output  1  plaintext_out holds the result of the last accepted request.
- REQ-008 plaintext_out  output  128  registered decrypted block.
- REQ-009 SHALL have no parameters.

Function
- REQ-010 SHALL implement the FIPS-197 AES-128 inverse cipher, bit-exact.
- REQ-011 Byte order: byte 0 = bits [127:120] for key, ciphertext and plaintext_out; bytes map to state column-major (byte n -> row n%4, column n/4).
- REQ-012 Architecture: iterative, one operation per cycle, one 128-bit state register, one 128-bit round-key register, and a 4-bit round counter.
- REQ-013 States: IDLE, KEXP, INIT, ROUND, DONE.
- REQ-014 Accept edge (IDLE or DONE with start=1) behaviour:
  - latch ciphertext into the state register and key into the round-key register;
  - clear valid and set round=1;
  - go to KEXP.
- REQ-015 KEXP, 10 cycles: round key <= forward-expanded next key using Rcon[round], round++; after round 10 go to INIT, with the round-key register holding rk10.
- REQ-016 INIT, 1 cycle: state <= state XOR rk10; go to ROUND with round=9.
- REQ-017 ROUND, each cycle:
  - rk_prev = inverse key expansion of the current round key using Rcon[round+1];
  - state <= InvShiftRows, then InvSubBytes, then XOR rk_prev;
  - InvMixColumns is applied as well when round != 0;
  - round key <= rk_prev; round--.
- REQ-018 Inverse key expansion: w[i] = w[i+4] XOR w[i+3] for i = 1..3; w0 = w4 XOR SubWord(RotWord(w3_new)) XOR Rcon.
- REQ-019 When round 0 completes:
  - plaintext_out <= result and valid <= 1 on the same edge;
  - go to DONE.
- REQ-020 Latency: the accept edge is E0; valid and plaintext_out update at E21 (21 cycles), i.e. 10 KEXP + 1 INIT + 10 ROUND.
- REQ-021 DONE:
  - valid stays 1 and plaintext_out stays stable until the next start is accepted;
  - valid falls at the accept edge;
  - plaintext_out keeps its old value until E21 of the new request.
- REQ-022 start while busy (KEXP/INIT/ROUND) SHALL be ignored.
- REQ-023 Changes on key or ciphertext after the accept edge SHALL NOT affect the result.
- REQ-024 The S-box and inverse S-box SHALL be combinational lookup; Rcon = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- REQ-025 Decrypting the output of the team's AES-128 encryptor with the same key SHALL return the original plaintext.

Reset
- REQ-026 rst_n=0 SHALL asynchronously force state IDLE, valid=0, plaintext_out=0, the state and round-key registers to 0, and round=0.
- REQ-027 Reset asserted mid-operation SHALL abort the operation with no valid pulse; after release the block idles until start.
- REQ-028 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
- REQ-029 key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext_out 00112233445566778899aabbccddeeff, with valid rising exactly 21 cycles after the accept edge.
- REQ-030 key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plaintext_out 3243f6a8885a308d313198a2e0370734.
- REQ-031 Round trip, key 000102030405060708090a0b0c0d0e0f:
  - take the reference-model encryption of ASCII "Hello, AES World" (48656c6c6f2c2041455320576f726c64);
  - decrypting it -> 48656c6c6f2c2041455320576f726c64.
- REQ-032 Pulse start again at cycle 5 of a run, with different inputs -> ignored; the result still matches the first request at E21.
- REQ-033 Drop rst_n at cycle 15 of a run -> valid=0 and plaintext_out=0 immediately; no valid afterwards until a new start.
- REQ-034 Back-to-back: start in DONE with a new vector -> valid drops at the accept edge and the new result appears 21 cycles later; the old plaintext_out holds meanwhile.
